// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
// It tracks the destination tags and remaining-latency counters of the
// instructions in E, M and W. From these and the ID-stage operands it
// derives the stall/bubble request and the D/E/M forwarding selects.
//
// Build option: define HAZARD_FWD_EN for full forwarding with latency-aware
// stalls. When it is undefined, all forwarding selects are 0 and any in-flight
// producer in E or M of a used source register stalls the pipeline.
//
// Ports:
//   clk, rst_n        core clock; synchronous active-low reset
//   rs_D, rt_D        source register fields of the ID instruction
//   dst_D             destination register of the ID instruction (0 = none)
//   Tuse_rs, Tuse_rt  cycles from ID until rs/rt is needed (rt: 3 = unused)
//   Tnew_D            cycles after entering EX until the result exists
//   stall             freeze PC and F/D, bubble into D/E
//   fwd_rs_D/rt_D     ID source: 0 regfile, 1 E result, 2 M result
//   fwd_rs_E/rt_E     EX source: 0 pipe reg, 1 M result, 2 W result
//   fwd_rt_M          DM store data: 0 pipe reg, 1 W result
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] dst_D,
  input  logic       Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [1:0] Tnew_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M
);

  logic [4:0] dst_E_q, dst_E_d;
  logic [4:0] dst_M_q, dst_M_d;

`ifdef HAZARD_FWD_EN
  logic [1:0] Tnew_E_q, Tnew_E_d;
  logic [1:0] Tnew_M_q, Tnew_M_d;
  logic [4:0] rs_E_q, rs_E_d;
  logic [4:0] rt_E_q, rt_E_d;
  logic [4:0] rt_M_q, rt_M_d;
  logic [4:0] dst_W_q, dst_W_d;

  // The E producer is younger than the M producer, so when both match it
  // alone decides whether the consumer must wait.
  function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] de, input logic [1:0] te,
                                     input logic [4:0] dm, input logic [1:0] tm);
    if (src == 5'd0) return 1'b0;
    if (src == de)   return te > tuse;
    if (src == dm)   return tm > tuse;
    return 1'b0;
  endfunction

  // Same E-first ordering for the ID forwarding select.
  function automatic logic [1:0] src_fwd_D(input logic [4:0] src,
                                           input logic [4:0] de, input logic [1:0] te,
                                           input logic [4:0] dm, input logic [1:0] tm);
    if (src == 5'd0) return 2'd0;
    if (src == de)   return (te == 2'd0) ? 2'd1 : 2'd0;
    if (src == dm)   return (tm == 2'd0) ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] src_fwd_E(input logic [4:0] src,
                                           input logic [4:0] dm, input logic [1:0] tm,
                                           input logic [4:0] dw);
    if (src != 5'd0 && src == dm && tm == 2'd0) return 2'd1;
    if (src != 5'd0 && src == dw)               return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    stall    = src_stall(rs_D, {1'b0, Tuse_rs}, dst_E_q, Tnew_E_q, dst_M_q, Tnew_M_q)
             | src_stall(rt_D, Tuse_rt, dst_E_q, Tnew_E_q, dst_M_q, Tnew_M_q);
    fwd_rs_D = src_fwd_D(rs_D, dst_E_q, Tnew_E_q, dst_M_q, Tnew_M_q);
    fwd_rt_D = src_fwd_D(rt_D, dst_E_q, Tnew_E_q, dst_M_q, Tnew_M_q);
    fwd_rs_E = src_fwd_E(rs_E_q, dst_M_q, Tnew_M_q, dst_W_q);
    fwd_rt_E = src_fwd_E(rt_E_q, dst_M_q, Tnew_M_q, dst_W_q);
    fwd_rt_M = (rt_M_q != 5'd0) && (rt_M_q == dst_W_q);
  end

  always_comb begin
    dst_E_d  = stall ? '0 : dst_D;
    Tnew_E_d = stall ? '0 : Tnew_D;
    rs_E_d   = stall ? '0 : rs_D;
    rt_E_d   = stall ? '0 : rt_D;
    dst_M_d  = dst_E_q;
    Tnew_M_d = (Tnew_E_q == 2'd0) ? 2'd0 : Tnew_E_q - 2'd1;
    rt_M_d   = rt_E_q;
    dst_W_d  = dst_M_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_E_q  <= '0;
      Tnew_E_q <= '0;
      rs_E_q   <= '0;
      rt_E_q   <= '0;
      dst_M_q  <= '0;
      Tnew_M_q <= '0;
      rt_M_q   <= '0;
      dst_W_q  <= '0;
    end else begin
      dst_E_q  <= dst_E_d;
      Tnew_E_q <= Tnew_E_d;
      rs_E_q   <= rs_E_d;
      rt_E_q   <= rt_E_d;
      dst_M_q  <= dst_M_d;
      Tnew_M_q <= Tnew_M_d;
      rt_M_q   <= rt_M_d;
      dst_W_q  <= dst_W_d;
    end
  end
`else
  logic rs_hit, rt_hit;
  logic unused_timing;

  // Without forwarding only the tags matter; W is covered by the
  // write-first regfile, so E and M are the only hazard sources.
  assign unused_timing = ^{Tuse_rs, Tnew_D};

  always_comb begin
    rs_hit   = (rs_D != 5'd0) && ((rs_D == dst_E_q) || (rs_D == dst_M_q));
    rt_hit   = (rt_D != 5'd0) && (Tuse_rt != 2'd3)
             && ((rt_D == dst_E_q) || (rt_D == dst_M_q));
    stall    = rs_hit | rt_hit;
    fwd_rs_D = '0;
    fwd_rt_D = '0;
    fwd_rs_E = '0;
    fwd_rt_E = '0;
    fwd_rt_M = 1'b0;
  end

  always_comb begin
    dst_E_d = stall ? '0 : dst_D;
    dst_M_d = dst_E_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_E_q <= '0;
      dst_M_q <= '0;
    end else begin
      dst_E_q <= dst_E_d;
      dst_M_q <= dst_M_d;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, dst_D;
  logic       Tuse_rs;
  logic [1:0] Tuse_rt, Tnew_D;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;

  hazard_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_D     (rs_D),
    .rt_D     (rt_D),
    .dst_D    (dst_D),
    .Tuse_rs  (Tuse_rs),
    .Tuse_rt  (Tuse_rt),
    .Tnew_D   (Tnew_D),
    .stall    (stall),
    .fwd_rs_D (fwd_rs_D),
    .fwd_rt_D (fwd_rt_D),
    .fwd_rs_E (fwd_rs_E),
    .fwd_rt_E (fwd_rt_E),
    .fwd_rt_M (fwd_rt_M)
  );

  typedef struct packed {
    logic       st;
    logic [1:0] rsD;
    logic [1:0] rtD;
    logic [1:0] rsE;
    logic [1:0] rtE;
    logic       rtM;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } item_t;

  item_t sb_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [4:0] Z  = 5'd0;
  localparam logic [4:0] T0 = 5'd8;
  localparam logic [4:0] T1 = 5'd9;
  localparam logic [4:0] T2 = 5'd10;
  localparam logic [4:0] S0 = 5'd16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic st, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d, input logic m);
    exp_t r;
    r = {st, a, b, c, d, m};
    return r;
  endfunction

  // One ID cycle: drive inputs just after the edge, queue the expected outputs.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input logic tur, input logic [1:0] tut,
                      input logic [1:0] tn, input bit chk, input exp_t e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    rst_n = rst; rs_D = rs; rt_D = rt; dst_D = dst;
    Tuse_rs = tur; Tuse_rt = tut; Tnew_D = tn;
    if (chk) begin
      it.e = e;
      it.name = nm;
      sb_q.push_back(it);
    end
  endtask

  // Monitor: outputs are combinational, so every queued entry is checked
  // mid-cycle on the falling edge.
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M};
        total++;
        if (act !== it.e) begin
          bad++;
          $display("FAIL %s: got st=%0d rsD=%0d rtD=%0d rsE=%0d rtE=%0d rtM=%0d want st=%0d rsD=%0d rtD=%0d rsE=%0d rtE=%0d rtM=%0d",
                   it.name, act.st, act.rsD, act.rtD, act.rsE, act.rtE, act.rtM,
                   it.e.st, it.e.rsD, it.e.rtD, it.e.rsE, it.e.rtE, it.e.rtM);
        end
      end
    end
  end

  initial begin
    exp_t z;
    int unsigned wait_cyc;
    z = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; rs_D = '0; rt_D = '0; dst_D = '0;
    Tuse_rs = 1'b1; Tuse_rt = 2'd3; Tnew_D = 2'd0;

`ifdef HAZARD_FWD_EN
    step(0, Z,  Z,  Z,  1, 3, 0, 0, z,                  "rst0");
    step(0, Z,  Z,  Z,  1, 3, 0, 1, z,                  "reset_state");
    // lw $t0 ; addu $t1,$t0,$t2
    step(1, S0, Z,  T0, 1, 3, 2, 1, z,                  "lw_t0");
    step(1, T0, T2, T1, 1, 1, 1, 1, mk(1, 0, 0, 0, 0, 0), "lw_use_stall");
    step(1, T0, T2, T1, 1, 1, 1, 1, z,                  "lw_use_release");
    step(1, Z,  Z,  Z,  1, 3, 0, 1, mk(0, 0, 0, 2, 0, 0), "lw_use_fwdW_E");
    // addu $t0 ; beq $t0,$t1
    step(1, T1, T2, T0, 1, 1, 1, 1, mk(0, 2, 0, 0, 0, 0), "addu_fwdM_D");
    step(1, T0, T1, Z,  0, 0, 0, 1, mk(1, 0, 0, 2, 0, 0), "beq_stall");
    step(1, T0, T1, Z,  0, 0, 0, 1, mk(0, 2, 0, 0, 0, 0), "beq_fwdM_D");
    // addu $t0 ; sw $t0,0($s0)
    step(1, T1, T2, T0, 1, 1, 1, 1, mk(0, 0, 0, 2, 0, 0), "beq_E_fwdW");
    step(1, S0, T0, Z,  1, 2, 0, 1, z,                  "sw_nostall");
    step(1, Z,  Z,  Z,  1, 3, 0, 1, mk(0, 0, 0, 0, 1, 0), "sw_fwdM_E");
    step(1, Z,  Z,  Z,  1, 3, 0, 1, mk(0, 0, 0, 0, 0, 1), "sw_fwdW_M");
    // writer of $0 ; reader of $0
    step(1, T1, T2, Z,  1, 1, 2, 1, z,                  "wr_zero");
    step(1, Z,  Z,  Z,  0, 0, 0, 1, z,                  "rd_zero");
    // lw $t0 ; jr $t0 with reset during the second stall cycle
    step(1, S0, Z,  T0, 1, 3, 2, 1, z,                  "lw_t0_b");
    step(1, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr_stall1");
    step(0, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr_stall2_rst");
    step(1, T0, Z,  Z,  0, 3, 0, 1, z,                  "post_reset");
    // lw $t0 ; jr $t0 uninterrupted
    step(1, S0, Z,  T0, 1, 3, 2, 1, z,                  "lw_t0_c");
    step(1, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr2_stall1");
    step(1, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr2_stall2");
    step(1, T0, Z,  Z,  0, 3, 0, 1, z,                  "jr2_go_regfile");
    // lw $t0 ; Tnew=0 writer of $t0 ; Tuse=0 reader: the E producer wins
    step(1, S0, Z,  T0, 1, 3, 2, 1, z,                  "lw_t0_d");
    step(1, Z,  Z,  T0, 1, 3, 0, 1, z,                  "quick_wr_t0");
    step(1, T0, Z,  Z,  0, 3, 0, 1, mk(0, 1, 0, 0, 0, 0), "e_over_m");
`else
    step(0, Z,  Z,  Z,  1, 3, 0, 0, z,                  "rst0");
    step(0, Z,  Z,  Z,  1, 3, 0, 1, z,                  "reset_state");
    // addu $t0 ; addu $t1,$t0,$t0
    step(1, T1, T2, T0, 1, 1, 1, 1, z,                  "addu_t0");
    step(1, T0, T0, T1, 1, 1, 1, 1, mk(1, 0, 0, 0, 0, 0), "raw_in_E");
    step(1, T0, T0, T1, 1, 1, 1, 1, mk(1, 0, 0, 0, 0, 0), "raw_in_M");
    step(1, T0, T0, T1, 1, 1, 1, 1, z,                  "raw_in_W");
    step(1, Z,  Z,  Z,  1, 3, 0, 1, z,                  "nop");
    step(1, Z,  T1, Z,  1, 3, 0, 1, z,                  "rt_unused");
    step(1, Z,  Z,  Z,  1, 1, 1, 1, z,                  "wr_zero");
    step(1, Z,  Z,  Z,  0, 0, 0, 1, z,                  "rd_zero");
    // lw $t0 ; jr $t0 with reset during the second stall cycle
    step(1, S0, Z,  T0, 1, 3, 2, 1, z,                  "lw_t0");
    step(1, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr_stall1");
    step(0, T0, Z,  Z,  0, 3, 0, 1, mk(1, 0, 0, 0, 0, 0), "jr_stall2_rst");
    step(1, T0, Z,  Z,  0, 3, 0, 1, z,                  "post_reset");
    // addu $t2 ; sw $t2,0($s0): rt hazard
    step(1, Z,  Z,  T2, 1, 1, 1, 1, z,                  "addu_t2");
    step(1, S0, T2, Z,  1, 2, 0, 1, mk(1, 0, 0, 0, 0, 0), "rt_in_E");
    step(1, S0, T2, Z,  1, 2, 0, 1, mk(1, 0, 0, 0, 0, 0), "rt_in_M");
    step(1, S0, T2, Z,  1, 2, 0, 1, z,                  "rt_clear");
`endif

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
